// File: rtl/evm_display_pkg.sv
// Shared constants for the EVM display path: BCD geometry, display limit,
// converter state encoding and the letter codes used by the segment driver.
package evm_display_pkg;

  localparam int unsigned BCD_DIGITS  = 5;
  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned BCD_W       = BCD_DIGITS * DIGIT_W;
  localparam int unsigned MAX_DISPLAY = 99999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  // Non-numeric glyphs understood by the seven-segment controller
  localparam logic [DIGIT_W-1:0] CODE_D = 4'd10;
  localparam logic [DIGIT_W-1:0] CODE_O = 4'd11;
  localparam logic [DIGIT_W-1:0] CODE_N = 4'd12;
  localparam logic [DIGIT_W-1:0] CODE_C = 4'd13;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit corrector: adds 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decade.
module bcd_add3
  import evm_display_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] digit_adj_c
);

  // Correct digit ahead of the shift
  always_comb begin
    digit_adj_c = digit;
    if (digit >= DIGIT_W'(5)) begin
      digit_adj_c = digit + DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/vote_bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock)
// feeding the seven-segment display multiplexer. bcd_out/overflow only move
// in the LOAD cycle so the display never sees partial results.
// Build option: define SATURATE_EN to clamp out-of-range tallies to all nines;
// otherwise the result is the tally modulo 100000.
module vote_bcd_converter #(
  parameter int unsigned BIN_WIDTH  = 17,
  parameter int unsigned BCD_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [BIN_WIDTH-1:0]    bin_in,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [4*BCD_DIGITS-1:0] bcd_out
);

  import evm_display_pkg::*;

  localparam int unsigned SCR_W = DIGIT_W * BCD_DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);

  state_t               state_q;
  state_t               state_d;
  logic [BIN_WIDTH-1:0] shift_q;
  logic [SCR_W-1:0]     scratch_q;
  logic [SCR_W-1:0]     scratch_adj_c;
  logic [CNT_W-1:0]     cnt_q;
  logic                 ovf_q;
  logic                 capture_c;
  logic                 shift_c;
  logic                 load_c;

  // One add-3 corrector per decade of the scratch register
  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_digit
    bcd_add3 u_add3 (
      .digit       (scratch_q[g*DIGIT_W +: DIGIT_W]),
      .digit_adj_c (scratch_adj_c[g*DIGIT_W +: DIGIT_W])
    );
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: SHIFT runs until the last bit, counted down from BIN_WIDTH
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_d = LOAD;
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath strobes decoded from state; start is only honoured in IDLE
  always_comb begin
    capture_c = 1'b0;
    shift_c   = 1'b0;
    load_c    = 1'b0;
    case (state_q)
      IDLE:    capture_c = start;
      SHIFT:   shift_c   = 1'b1;
      LOAD:    load_c    = 1'b1;
      default: ;
    endcase
  end

  // Scratch datapath and registered outputs; top-digit carries fall off the shift
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      bcd_out   <= '0;
    end else begin
      done <= 1'b0;
      if (capture_c) begin
        shift_q   <= bin_in;
        scratch_q <= '0;
        cnt_q     <= CNT_W'(BIN_WIDTH);
        ovf_q     <= (32'(bin_in) > MAX_DISPLAY);
        busy      <= 1'b1;
      end
      if (shift_c) begin
        {scratch_q, shift_q} <= {scratch_adj_c, shift_q} << 1;
        cnt_q                <= cnt_q - CNT_W'(1);
      end
      if (load_c) begin
        busy     <= 1'b0;
        done     <= 1'b1;
        overflow <= ovf_q;
`ifdef SATURATE_EN
        bcd_out  <= ovf_q ? {BCD_DIGITS{4'h9}} : scratch_q;
`else
        bcd_out  <= scratch_q;
`endif
      end
    end
  end

endmodule

// File: tb/tb_vote_bcd_converter.sv
// Self-checking bench for vote_bcd_converter: directed corner cases plus
// randomized tallies with start/bin_in noise during conversions.
module tb_vote_bcd_converter;

  localparam int unsigned BIN_WIDTH = 17;
  localparam int unsigned LAT       = BIN_WIDTH + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [16:0] bin_in;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [19:0] bcd_out;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [19:0] exp_bcd  = '0;
  logic        exp_ovf  = 1'b0;

  vote_bcd_converter #(.BIN_WIDTH(17), .BCD_DIGITS(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .bcd_out  (bcd_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  // Decimal digits of the displayed value, built arithmetically
  function automatic logic [19:0] model_bcd(input int unsigned v);
    int unsigned x;
    logic [19:0] r;
`ifdef SATURATE_EN
    x = (v > 99999) ? 99999 : v;
`else
    x = v % 100000;
`endif
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One conversion; optional noise on start/bin_in while busy
  task automatic convert(input int unsigned v, input string tag, input bit poke);
    int cyc;
    int busy_cyc;
    int unstable;
    bit seen;
    cyc = 0; busy_cyc = 0; unstable = 0; seen = 0;
    start  = 1'b1;
    bin_in = 17'(v);
    tick();
    start = 1'b0;
    while (!seen && cyc < 60) begin
      if (busy) busy_cyc++;
      if (done) begin
        seen = 1'b1;
      end else begin
        if (bcd_out !== exp_bcd || overflow !== exp_ovf) unstable++;
        if (poke) begin
          start  = 1'($urandom_range(0, 1));
          bin_in = 17'($urandom);
        end
        tick();
        cyc++;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(cyc), 32'(LAT));
    check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(LAT));
    check({tag, "_hold"}, 32'(unstable), 32'd0);
    exp_bcd = model_bcd(v);
    exp_ovf = (v > 99999);
    check({tag, "_bcd"}, 32'(bcd_out), 32'(exp_bcd));
    check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n_done;
    int c;
    int first_done;
    int second_done;
    int unsigned a;
    int unsigned b;

    reset = 1'b1; start = 1'b0; bin_in = '0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf",  32'(overflow), 32'd0);
    check("rst_bcd",  32'(bcd_out), 32'd0);
    reset = 1'b0;
    tick();

    convert(0,      "zero",   1'b0);
    convert(12345,  "v12345", 1'b0);
    convert(99999,  "max",    1'b0);
    convert(9,      "nine",   1'b0);
    convert(100000, "ovf_lo", 1'b0);
    convert(131071, "ovf_hi", 1'b0);
    convert(99999,  "max2",   1'b0);

    // Second start 5 cycles in must be ignored
    start = 1'b1; bin_in = 17'd42;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1; bin_in = 17'd77;
    tick();
    start = 1'b0; bin_in = 17'd0;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        n_done++;
        check("ign_bcd", 32'(bcd_out), 32'h00042);
      end
      tick();
    end
    check("ign_done_count", 32'(n_done), 32'd1);
    exp_bcd = 20'h00042; exp_ovf = 1'b0;

    // Start held high: back-to-back conversions every BIN_WIDTH+2 cycles
    a = $urandom_range(0, 131071);
    b = $urandom_range(0, 99999);
    start = 1'b1; bin_in = 17'(a);
    tick();
    bin_in = 17'(b);
    c = 0; first_done = -1; second_done = -1;
    while (second_done < 0 && c < 80) begin
      if (done) begin
        if (first_done < 0) begin
          first_done = c;
          check("b2b_first_bcd", 32'(bcd_out), 32'(model_bcd(a)));
        end else begin
          second_done = c;
          start = 1'b0;
        end
      end
      tick();
      c++;
    end
    start = 1'b0;
    check("b2b_first_lat", 32'(first_done), 32'(LAT));
    check("b2b_period", 32'(second_done - first_done), 32'(BIN_WIDTH + 2));
    check("b2b_second_bcd", 32'(bcd_out), 32'(model_bcd(b)));
    exp_bcd = model_bcd(b); exp_ovf = 1'b0;
    repeat (2) tick();
    check("b2b_stopped", 32'(busy), 32'd0);

    // Reset in the middle of a conversion aborts it silently
    start = 1'b1; bin_in = 17'd54321;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_bcd",  32'(bcd_out), 32'd0);
    check("abort_ovf",  32'(overflow), 32'd0);
    n_done = 0;
    for (int i = 0; i < 25; i++) begin
      if (done || busy) n_done++;
      tick();
    end
    check("abort_quiet", 32'(n_done), 32'd0);
    exp_bcd = '0; exp_ovf = 1'b0;
    convert(7, "after_abort", 1'b0);

    // Randomized tallies with noise on start/bin_in while busy
    for (int i = 0; i < 25; i++) begin
      convert($urandom_range(0, 131071), $sformatf("rnd%0d", i), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vote_bcd_converter.md
Name: vote_bcd_converter

Overview:
Sequential binary-to-BCD converter that sits directly upstream of the seven-segment display controller. It takes a binary vote tally and produces the packed 5-digit BCD word the display multiplexer consumes. It uses iterative shift-and-add-3 (double dabble), one bit per clock. The BCD output is held stable between conversions so the multiplexed display never shows intermediate values.

Parameters:
BIN_WIDTH, 17, width of binary input; 17 bits covers 0..131071.
BCD_DIGITS, 5, number of BCD digits produced; fixed at 5 to match the 20-bit display input.

Ports:
clk  input  1  system clock (100 MHz)
reset  input  1  synchronous, active-high reset
start  input  1  request a conversion of bin_in; sampled on the rising edge of clk
bin_in  input  BIN_WIDTH  binary value; captured only in the cycle start is accepted
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when bcd_out has been updated
overflow  output  1  set when the captured value exceeded 99999; held with bcd_out
bcd_out  output  4*BCD_DIGITS  packed BCD: [3:0] ones, [7:4] tens, [11:8] hundreds, [15:12] thousands, [19:16] ten-thousands

Behaviour:
- One clock, clk. Reset is synchronous and active-high; no asynchronous logic.
- Reset values: busy=0, done=0, overflow=0, bcd_out=0, state=IDLE, internal shift/BCD registers=0, bit counter=0.
- States:
  - IDLE: if start=1, capture bin_in into the shift register, clear the BCD scratch register, load bit counter = BIN_WIDTH, set busy=1, go to SHIFT. Also set the overflow scratch flag if bin_in > 99999.
  - SHIFT: each cycle, add 3 to every scratch digit >= 5, then shift {scratch, shift_reg} left by 1 and decrement the counter. When the counter reaches 1 on this edge (the last bit), go to LOAD.
  - LOAD: write bcd_out and overflow from scratch, pulse done=1 for exactly this one cycle, clear busy, return to IDLE.
- Latency: start sampled at edge 0 -> BIN_WIDTH SHIFT edges -> LOAD edge. done is visible BIN_WIDTH+1 cycles after the start edge (18 cycles by default). busy is high for BIN_WIDTH+1 cycles.
- Start while busy (SHIFT or LOAD) is ignored, not queued. bin_in changes during a conversion have no effect.
- Start held high continuously: a new conversion begins in the IDLE cycle that follows LOAD, giving back-to-back conversions every BIN_WIDTH+2 cycles.
- bcd_out and overflow change only in LOAD; they are stable at all other times, including during SHIFT.
- Carries out of the ten-thousands digit are discarded, so the raw result is value mod 100000.
- Every digit of bcd_out is always 0..9; codes 10..13 (display letters) are never emitted by this block.
- Reset mid-conversion: abort immediately, all outputs return to their reset values, and no done pulse is produced.

Optional Feature:
SATURATE_EN macro.
- Defined: if the captured value > 99999, bcd_out is loaded with 0x99999 and overflow=1.
- Undefined: bcd_out = value mod 100000 (natural truncation) and overflow=1.
- In both cases overflow=0 when value <= 99999. Latency is identical with and without the macro.

Decomposition:
- Shared package evm_display_pkg:
  - BCD_DIGITS=5, DIGIT_W=4, BCD_W=20
  - MAX_DISPLAY=99999
  - state encoding IDLE/SHIFT/LOAD
  - display letter codes D=10, O=11, N=12, C=13
- One natural sub-module: bcd_add3, a combinational 4-bit corrector (digit >= 5 ? digit+3 : digit). It is instantiated BCD_DIGITS times in the SHIFT datapath.

Test Plan:
- Reset, then start with bin_in=0 -> done 18 cycles later; bcd_out=0x00000, overflow=0.
- start with bin_in=12345 -> busy high for 18 cycles; bcd_out stays at its old value until done; then bcd_out=0x12345.
- bin_in=99999 -> bcd_out=0x99999, overflow=0. Then bin_in=9 -> bcd_out=0x00009.
- bin_in=100000 -> overflow=1. With SATURATE_EN, bcd_out=0x99999; without it, bcd_out=0x00000. Also bin_in=131071 without SATURATE_EN -> 0x31071.
- Pulse start with 42 and again 5 cycles later with 77 -> exactly one done pulse, bcd_out=0x00042; the second start is ignored.
- Start with 54321 and assert reset at cycle 10 -> busy=0, bcd_out=0, no done. Then start with 7 -> 0x00007 after 18 cycles.
